// File: rtl/icache_pkg.sv
// icache_pkg: shared types, constants and address-field width helpers for the
// direct-mapped instruction cache.
//   state_e        : controller states (IDLE, MISS, FILL)
//   NOP_INSTR      : instruction returned whenever fetch is not ready/disabled
//   LINE_WORDS     : 32-bit words per cache line
//   LINE_BITS      : line width in bits
//   offset_w/index_w/tag_w : address field widths for a given line count
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          LINE_WORDS = 4;
  localparam int          LINE_BITS  = 128;
  localparam int          ADDR_BITS  = 32;

  // Byte-offset bits inside one line: 2 byte-select + word-select bits.
  function automatic int offset_w();
    return $clog2(LINE_WORDS) + 2;
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return ADDR_BITS - offset_w() - index_w(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: tag, valid and data storage for the direct-mapped cache.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset (valid bits only)
//   flush_i           : clear every valid bit at the next edge (beats a write)
//   rd_idx_i          : combinational read index
//   rd_valid_o/rd_tag_o/rd_data_o : contents of the addressed line
//   wr_en_i, wr_idx_i, wr_tag_i, wr_data_i : single write port; sets valid
module icache_array
  import icache_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int IDX_W = index_w(LINES),
  localparam int TAG_W = tag_w(LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_valid_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i
);

  // Tag and data carry no reset; a line is only trusted through its valid bit.
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  wire  [LINES-1:0]     valid_w;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // One flop per line so flush can clear them all in a single edge.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    logic valid_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
        valid_q <= 1'b1;
      end
    end
    assign valid_w[gi] = valid_q;
  end

  // Combinational read keeps hits zero-latency.
  assign rd_valid_o = valid_w[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller with one
// outstanding line refill.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   enable_i      : fetch enable
//   pc_i          : fetch address
//   flush_i       : invalidate all lines (fence.i)
//   instr_o       : fetched instruction, NOP while stalled or disabled
//   stall_o       : fetch not ready
//   mem_req_o     : refill request, held until mem_ack_i
//   mem_addr_o    : line-aligned refill address
//   mem_ack_i     : one-cycle refill-data-valid pulse
//   mem_data_i    : refill line, word 0 in bits [31:0]
//   miss_cnt_o    : saturating miss counter
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [31:0]          pc_i,
  input  logic                 flush_i,
  output logic [31:0]          instr_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic [31:0]          mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic [15:0]          miss_cnt_o
);

  localparam int IDX_W  = index_w(LINES);
  localparam int TAG_W  = tag_w(LINES);
  localparam int OFF_W  = offset_w();
  localparam int WSEL_W = $clog2(LINE_WORDS);

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  // Set when a flush lands while the refill is outstanding: the returning
  // line predates the flush and must not become valid.
  logic        discard_q, discard_d;

  logic [WSEL_W-1:0]    pc_wsel;
  logic [IDX_W-1:0]     pc_idx, fill_idx;
  logic [TAG_W-1:0]     pc_tag, fill_tag;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 hit;
  logic                 fill_we;
  logic                 unused_bits;

  assign pc_wsel  = pc_i[2 +: WSEL_W];
  assign pc_idx   = pc_i[OFF_W +: IDX_W];
  assign pc_tag   = pc_i[OFF_W+IDX_W +: TAG_W];
  // Fill location comes from the latched address, not pc_i, which may move.
  assign fill_idx = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag = mem_addr_q[OFF_W+IDX_W +: TAG_W];
  assign unused_bits = ^pc_i[1:0];

  icache_array #(.LINES(LINES)) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .rd_idx_i  (pc_idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (fill_we),
    .wr_idx_i  (fill_idx),
    .wr_tag_i  (fill_tag),
    .wr_data_i (mem_data_i)
  );

  assign hit = (state_q == ST_IDLE) && enable_i && rd_valid && (rd_tag == pc_tag);

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    miss_cnt_d = miss_cnt_q;
    discard_d  = discard_q;
    fill_we    = 1'b0;
    mem_req_o  = 1'b0;
    stall_o    = 1'b0;
    instr_o    = NOP_INSTR;
    unique case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (enable_i) begin
          if (hit) begin
            instr_o = rd_data[{pc_wsel, 5'd0} +: 32];
          end else begin
            stall_o    = 1'b1;
            mem_addr_d = {pc_i[31:OFF_W], {OFF_W{1'b0}}};
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_d = miss_cnt_q + 16'd1;
            end
            state_d = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (mem_ack_i) begin
          // A flush in the ack cycle also discards the line.
          fill_we = !(discard_q || flush_i);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        stall_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      miss_cnt_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      miss_cnt_q <= miss_cnt_d;
      discard_q  <= discard_d;
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl. The reference model
// tracks which line address is resident at each index and derives line
// contents from a deterministic backing-memory function.
module tb_icache_ctrl;

  localparam int          LINES = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic [31:0]  pc_i;
  logic         flush_i;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;
  logic [15:0]  miss_cnt_o;

  always #5 clk_i = ~clk_i;

  icache_ctrl #(.LINES(LINES)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .instr_o   (instr_o),
    .stall_o   (stall_o),
    .mem_req_o (mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i (mem_ack_i),
    .mem_data_i(mem_data_i),
    .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index -> resident line address; counter.
  logic [31:0] resident [int];
  logic [15:0] m_cnt;

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (a == 32'h0) return {32'h00400093, 32'h00300113, 32'h00200193, 32'h00100213};
    return {a ^ 32'hC3C3_0003, a ^ 32'h5A5A_0002, a ^ 32'h0F0F_0001, a ^ 32'h9696_0000};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [127:0] l;
    l = mem_line({pc[31:4], 4'b0});
    return l[int'(pc[3:2]) * 32 +: 32];
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int idx;
    idx = int'(pc[7:4]);
    return resident.exists(idx) && (resident[idx] == {pc[31:4], 4'b0});
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // One lookup from IDLE. On a miss, serves the refill after 'delay' extra
  // MISS cycles; flush_at = k pulses flush in wait cycle k, = delay pulses it
  // with the ack, < 0 means no flush. Starts and ends at a falling edge.
  task automatic do_lookup(input logic [31:0] pc, input int delay, input int flush_at,
                           output bit was_hit);
    logic [31:0] la;
    bit exp_hit;
    bit discard;
    la = {pc[31:4], 4'b0};
    exp_hit = model_hit(pc);
    discard = 1'b0;
    enable_i = 1'b1; pc_i = pc; flush_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    $display("lookup pc=%08h %s instr=%08h stall=%b cnt=%04h",
             pc, exp_hit ? "hit " : "miss", instr_o, stall_o, miss_cnt_o);
    if (exp_hit) begin
      checks++;
      if (stall_o !== 1'b0 || instr_o !== exp_word(pc) || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL hit pc=%08h: got stall=%b instr=%08h req=%b, want stall=0 instr=%08h req=0",
                 pc, stall_o, instr_o, mem_req_o, exp_word(pc));
      end
      was_hit = 1'b1;
      @(negedge clk_i);
      return;
    end
    checks++;
    if (stall_o !== 1'b1 || instr_o !== NOP) begin
      errors++;
      $display("FAIL miss_detect pc=%08h: got stall=%b instr=%08h, want stall=1 instr=%08h",
               pc, stall_o, instr_o, NOP);
    end
    m_cnt = sat_inc(m_cnt);
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== la || miss_cnt_o !== m_cnt ||
        stall_o !== 1'b1 || instr_o !== NOP) begin
      errors++;
      $display("FAIL miss_req pc=%08h: got req=%b addr=%08h cnt=%04h stall=%b instr=%08h, want 1 %08h %04h 1 %08h",
               pc, mem_req_o, mem_addr_o, miss_cnt_o, stall_o, instr_o, la, m_cnt, NOP);
    end
    for (int k = 0; k < delay; k++) begin
      enable_i = 1'($urandom_range(0, 1));
      flush_i  = (k == flush_at);
      if (flush_i) begin
        resident.delete();
        discard = 1'b1;
      end
      @(negedge clk_i);
      flush_i = 1'b0;
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== la || stall_o !== 1'b1) begin
        errors++;
        $display("FAIL miss_hold pc=%08h cyc=%0d: got req=%b addr=%08h stall=%b, want 1 %08h 1",
                 pc, k, mem_req_o, mem_addr_o, stall_o, la);
      end
    end
    mem_ack_i  = 1'b1;
    mem_data_i = mem_line(la);
    flush_i    = (flush_at == delay);
    if (flush_i) begin
      resident.delete();
      discard = 1'b1;
    end
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    flush_i    = 1'b0;
    mem_data_i = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || instr_o !== NOP) begin
      errors++;
      $display("FAIL fill pc=%08h: got req=%b stall=%b instr=%08h, want 0 1 %08h",
               pc, mem_req_o, stall_o, instr_o, NOP);
    end
    if (!discard) resident[int'(la[7:4])] = la;
    @(negedge clk_i);
    was_hit = 1'b0;
  endtask

  task automatic fetch_until_hit(input logic [31:0] pc, input int delay, input int flush_at);
    bit h;
    h = 1'b0;
    for (int t = 0; t < 3 && !h; t++) begin
      do_lookup(pc, (t == 0) ? delay : $urandom_range(0, 3), (t == 0) ? flush_at : -1, h);
    end
  endtask

  task automatic do_flush_idle();
    enable_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || instr_o !== NOP) begin
      errors++;
      $display("FAIL flush_idle: got stall=%b req=%b instr=%08h, want 0 0 %08h",
               stall_o, mem_req_o, instr_o, NOP);
    end
    resident.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic do_stray_ack(input logic [31:0] pc);
    enable_i = 1'b0; pc_i = pc; mem_ack_i = 1'b1;
    mem_data_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checks++;
    if (stall_o !== 1'b0 || instr_o !== NOP || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL disabled pc=%08h: got stall=%b instr=%08h req=%b, want 0 %08h 0",
               pc, stall_o, instr_o, mem_req_o, NOP);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || miss_cnt_o !== m_cnt) begin
      errors++;
      $display("FAIL stray_ack: got req=%b cnt=%04h, want 0 %04h", mem_req_o, miss_cnt_o, m_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    resident.delete();
    m_cnt = 16'h0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || miss_cnt_o !== 16'h0 ||
        stall_o !== 1'b0 || instr_o !== NOP) begin
      errors++;
      $display("FAIL reset: got req=%b addr=%08h cnt=%04h stall=%b instr=%08h, want 0 0 0 0 %08h",
               mem_req_o, mem_addr_o, miss_cnt_o, stall_o, instr_o, NOP);
    end
    @(negedge clk_i);
  endtask

  task automatic test_cold_miss();
    bit h;
    do_lookup(32'h0, 3, -1, h);
    do_lookup(32'h0, 0, -1, h);
    checks++;
    if (h !== 1'b1 || miss_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL cold_miss: got hit=%b cnt=%04h, want 1 0001", h, miss_cnt_o);
    end
  endtask

  task automatic test_hits();
    logic [31:0] pcs  [3];
    logic [31:0] want [3];
    pcs  = '{32'h4, 32'h8, 32'hC};
    want = '{32'h00200193, 32'h00300113, 32'h00400093};
    for (int i = 0; i < 3; i++) begin
      enable_i = 1'b1; pc_i = pcs[i];
      #1;
      $display("lookup pc=%08h hit  instr=%08h stall=%b cnt=%04h", pc_i, instr_o, stall_o, miss_cnt_o);
      checks++;
      if (instr_o !== want[i] || stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL hit_word pc=%08h: got instr=%08h stall=%b req=%b, want %08h 0 0",
                 pcs[i], instr_o, stall_o, mem_req_o, want[i]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_conflict();
    fetch_until_hit(32'h100, 2, -1);
    fetch_until_hit(32'h0, 1, -1);
    checks++;
    if (miss_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL conflict_cnt: got %04h, want 0003", miss_cnt_o);
    end
  endtask

  task automatic test_flush_mid_miss();
    fetch_until_hit(32'h40, 4, 1);   // flush inside MISS
    fetch_until_hit(32'h54, 2, 2);   // flush coincident with ack
  endtask

  task automatic test_flush_idle();
    fetch_until_hit(32'h80, 1, -1);
    do_flush_idle();
    fetch_until_hit(32'h80, 0, -1);
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 4; i++) begin
      enable_i = 1'b0; pc_i = $urandom;
      #1;
      checks++;
      if (stall_o !== 1'b0 || instr_o !== NOP) begin
        errors++;
        $display("FAIL enable_low pc=%08h: got stall=%b instr=%08h, want 0 %08h", pc_i, stall_o, instr_o, NOP);
      end
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b0 || miss_cnt_o !== m_cnt) begin
        errors++;
        $display("FAIL enable_low_req: got req=%b cnt=%04h, want 0 %04h", mem_req_o, miss_cnt_o, m_cnt);
      end
    end
  endtask

  task automatic test_stray_ack();
    bit h;
    fetch_until_hit(32'h200, 1, -1);
    do_stray_ack(32'h200);
    do_lookup(32'h208, 0, -1, h);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int d;
    for (int it = 0; it < 200; it++) begin
      pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      case ($urandom_range(0, 9))
        0: do_flush_idle();
        1: do_stray_ack(pc);
        default: begin
          d = $urandom_range(0, 3);
          fetch_until_hit(pc, d, ($urandom_range(0, 6) == 0) ? $urandom_range(0, d) : -1);
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_miss();
    fetch_until_hit(32'h300, 1, -1);
    enable_i = 1'b1; pc_i = 32'h400;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req: got req=%b, want 1", mem_req_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || miss_cnt_o !== 16'h0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_miss: got req=%b cnt=%04h addr=%08h, want 0 0000 00000000",
               mem_req_o, miss_cnt_o, mem_addr_o);
    end
    resident.delete();
    m_cnt = 16'h0;
    @(negedge clk_i);
    rst_i = 1'b0; enable_i = 1'b0;
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_data_i = mem_line(32'h400);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_stray_ack: got req=%b stall=%b, want 0 0", mem_req_o, stall_o);
    end
    fetch_until_hit(32'h300, 0, -1);
    fetch_until_hit(32'h400, 1, -1);
    checks++;
    if (miss_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL rst_cnt: got %04h, want 0002", miss_cnt_o);
    end
  endtask

  task automatic test_saturation();
    do_flush_idle();
    force dut.miss_cnt_q = 16'hFFFD;
    #1 release dut.miss_cnt_q;
    m_cnt = 16'hFFFD;
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      fetch_until_hit(32'(k) << 8, 0, -1);
    end
    checks++;
    if (miss_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation: got %04h, want FFFF", miss_cnt_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; pc_i = 32'h0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0; m_cnt = 16'h0;
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_flush_mid_miss();
    test_flush_idle();
    test_enable_low();
    test_stray_ack();
    test_random();
    test_reset_mid_miss();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 SHALL have parameter LINE_WORDS, fixed 4, 32-bit words per line (128-bit line).
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 enable_i  input  1  fetch enable; core running.
REQ-006 pc_i  input  32  fetch address from the PC register.
REQ-007 flush_i  input  1  invalidate all lines (fence.i).
REQ-008 instr_o  output  32  fetched instruction.
REQ-009 stall_o  output  1  fetch not ready; PC and IF/ID hold.
REQ-010 mem_req_o  output  1  line-refill request to backing memory.
REQ-011 mem_addr_o  output  32  line-aligned refill address.
REQ-012 mem_ack_i  input  1  refill data valid, one-cycle pulse.
REQ-013 mem_data_i  input  128  refill line; word 0 in bits [31:0].
REQ-014 miss_cnt_o  output  16  saturating miss counter.

Function
REQ-015 Address split SHALL be: [1:0] ignored, [3:2] word select, [3+log2(LINES):4] index, remaining upper bits tag (LINES=16: index [7:4], tag [31:8]).
REQ-016 FSM SHALL have states IDLE, MISS, FILL.
REQ-017 In IDLE, hit SHALL be combinational: enable_i && valid[index] && tag[index]==pc_i tag.
REQ-018 On hit, instr_o SHALL be the selected word of the line in the same cycle (zero-latency), stall_o low.
REQ-019 instr_o SHALL be 32'h00000013 (NOP) whenever stall_o is high or enable_i is low.
REQ-020 stall_o SHALL be high when (IDLE && enable_i && !hit) or state is MISS or FILL.
REQ-021 IDLE && enable_i && !hit SHALL latch {pc_i[31:4],4'b0} into mem_addr_o, increment miss_cnt_o (saturate at 16'hFFFF), and go to MISS.
REQ-022 In MISS, mem_req_o SHALL be high and mem_addr_o stable until mem_ack_i sampled high.
REQ-023 On mem_ack_i in MISS, the line SHALL be written with mem_data_i, tag set, valid set; next state FILL; mem_req_o low from the next cycle.
REQ-024 FILL SHALL last exactly one cycle then return to IDLE, where the current pc_i is looked up again (hit expected).
REQ-025 Miss latency SHALL be: ack at edge N -> FILL during cycle N..N+1 -> hit with stall_o low in cycle after FILL.
REQ-026 mem_ack_i outside MISS SHALL be ignored.
REQ-027 flush_i SHALL clear every valid bit at the next edge, in any state.
REQ-028 flush_i during MISS SHALL NOT abort the request; the returned line SHALL be discarded (valid stays 0) and the FSM goes to FILL then IDLE, re-missing.
REQ-029 flush_i coincident with mem_ack_i SHALL discard the line (flush wins).
REQ-030 enable_i low in IDLE SHALL start no refill; enable_i low in MISS SHALL not abort the outstanding refill.
REQ-031 Lines with same index and different tag SHALL be replaced (no associativity).

Reset
REQ-032 Reset SHALL force state IDLE, all valid bits 0, mem_req_o 0, mem_addr_o 0, miss_cnt_o 0; stall_o follows REQ-020, instr_o NOP.
REQ-033 Tag and data arrays SHALL NOT require reset.
REQ-034 Reset during MISS SHALL drop mem_req_o immediately; a later stray mem_ack_i SHALL be ignored.

Structure
REQ-035 Package icache_pkg SHALL hold: state enum, NOP constant, LINE_WORDS, line width 128, offset/index/tag width functions.
REQ-036 One sub-module icache_array SHALL hold tag, valid and data storage with combinational read and single write port; FSM and counter stay in icache_ctrl.

Verification
REQ-037 Cold miss: reset, enable_i=1, pc_i=0x00000000, ack after 3 cycles with line {0x00400093,0x00300113,0x00200193,0x00100213} -> one request at addr 0x0, stall_o high until the cycle after FILL, then instr_o=0x00100213 (word 0, bits [31:0]), miss_cnt_o=1.
REQ-038 Hits: after fill, pc_i 0x4,0x8,0xC -> instr_o words 1..3 same cycle, stall_o low, no mem_req_o.
REQ-039 Conflict: pc_i=0x00000100 (index 0, tag 1) -> miss, request addr 0x100; return to pc_i=0x0 -> miss again, miss_cnt_o=3.
REQ-040 Flush mid-miss: flush_i pulse during MISS -> request completes, pc_i re-misses after FILL, second request same address.
REQ-041 Reset mid-miss: rst_i during MISS -> mem_req_o low immediately; ack pulse after reset ignored; all valid 0.
REQ-042 Counter saturation: force 65536+ misses (or preload) -> miss_cnt_o holds 16'hFFFF.
